pipe_exec_ctrl: RTL

Execution controller for the 5-stage MIPS pipeline, sitting between the debug/UART unit and the stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It gates pipeline advance with a common enable and supports continuous run and single-step. It detects the halt flag leaving EX/MEM, drains the remaining stages, then stops. It also counts executed cycles and issues a one-cycle flush to clear all stage registers.

---
 rtl/pipe_exec_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pipe_exec_ctrl.sv
// Execution controller for the 5-stage pipeline. It gates stage-register
// advance for run and single-step, drains the pipe after the halt flag
// leaves EX/MEM, counts enabled cycles and issues a one-cycle flush.
module pipe_exec_ctrl #(
  parameter int CBITS        = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  input  logic [1:0]       i_cmd,
  output logic             o_cmd_ready,
  input  logic             i_mem_haltflag,
  output logic             o_pipe_en,
  output logic             o_pipe_flush,
  output logic             o_busy,
  output logic             o_done,
  output logic [CBITS-1:0] o_cycle_count,
  output logic [2:0]       o_state
);

  localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_FLUSH = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4,
    S_FLUSH  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic [CBITS-1:0] cycle_count_q, cycle_count_d;
  logic             cmd_acc;
  logic             pipe_en;

  // Outputs depend on registered state only, so the debug unit never sees
  // a combinational path from its own strobe back to ready.
  always_comb begin
    pipe_en      = (state_q == S_RUN) || (state_q == S_STEP) || (state_q == S_DRAIN);
    o_pipe_en    = pipe_en;
    o_busy       = pipe_en;
    o_pipe_flush = (state_q == S_FLUSH);
    o_done       = (state_q == S_HALTED);
    o_cmd_ready  = (state_q == S_IDLE) || (state_q == S_HALTED);
    o_state      = state_q;
    o_cycle_count = cycle_count_q;
  end

  assign cmd_acc = i_cmd_valid && o_cmd_ready;

  // Next-state, drain counter and cycle counter.
  always_comb begin
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    cycle_count_d = cycle_count_q;

    // Saturating count of enabled edges; FLUSH zeroes it on its way out.
    if (state_q == S_FLUSH)
      cycle_count_d = '0;
    else if (pipe_en && (cycle_count_q != {CBITS{1'b1}}))
      cycle_count_d = cycle_count_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (cmd_acc) begin
          case (i_cmd)
            CMD_RUN:   state_d = S_RUN;
            CMD_STEP:  state_d = S_STEP;
            CMD_FLUSH: state_d = S_FLUSH;
            default:   state_d = S_IDLE;
          endcase
        end
      end
      S_RUN, S_STEP: begin
        // The halt-detect edge itself is an enabled edge; drain counts the
        // extra edges needed for MEM/WB to retire and WB to write back.
        if (i_mem_haltflag) begin
          if (DRAIN_CYCLES == 0) begin
            state_d = S_HALTED;
          end else begin
            state_d     = S_DRAIN;
            drain_cnt_d = DW'(DRAIN_CYCLES);
          end
        end else if (state_q == S_STEP) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        drain_cnt_d = drain_cnt_q - 1'b1;
        if (drain_cnt_q <= DW'(1))
          state_d = S_HALTED;
      end
      S_HALTED: begin
        // Only FLUSH leaves HALTED; other commands are consumed and dropped.
        if (cmd_acc && (i_cmd == CMD_FLUSH))
          state_d = S_FLUSH;
      end
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset taking priority over all else.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      drain_cnt_q   <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  logic unused_ok;
  assign unused_ok = (CMD_NOP == 2'b00);

endmodule
